// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: runs the soda motor per sale, pays change nickel-by-nickel via hopper handshake, tracks stock and faults
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES  = 8,
    parameter int EJECT_TIMEOUT = 16,
    parameter int NICKEL_W      = 6,
    parameter int NICKEL_INIT   = 31
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_vend,
    input  logic [2:0]          i_change,
    input  logic                i_eject_ack,
    input  logic                i_refill,
    input  logic                i_fault_clr,
    output logic                o_busy,
    output logic                o_motor,
    output logic                o_eject_req,
    output logic                o_done,
    output logic                o_change_fault,
    output logic                o_nickel_low,
    output logic [NICKEL_W-1:0] o_nickel_cnt
);
    localparam int TMAX = MOTOR_CYCLES > EJECT_TIMEOUT ? MOTOR_CYCLES : EJECT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    typedef enum logic [2:0] {IDLE, MOTOR, EJECT, GAP, DONE, FAULT} state_t;
    state_t              state;
    logic [2:0]          rem;
    logic [TW-1:0]       tmr;
    logic [NICKEL_W-1:0] stock;
    logic                ack_ok;
    assign ack_ok         = state == EJECT && i_eject_ack;
    assign o_busy         = state != IDLE;
    assign o_motor        = state == MOTOR;
    assign o_eject_req    = state == EJECT;
    assign o_done         = state == DONE;
    assign o_change_fault = state == FAULT;
    assign o_nickel_cnt   = stock;
    assign o_nickel_low   = stock <= NICKEL_W'(4);
    // sale sequencer: shared timer counts motor run time and hopper ack timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            rem   <= '0;
            tmr   <= '0;
        end else begin
            case (state)
                IDLE: if (i_vend) begin
                    rem   <= i_change > 3'd4 ? 3'd4 : i_change;
                    tmr   <= '0;
                    state <= MOTOR;
                end
                MOTOR: if (tmr == TW'(MOTOR_CYCLES - 1)) begin
                    tmr   <= '0;
                    state <= rem == 3'd0 ? DONE : stock == '0 ? FAULT : EJECT;
                end else begin
                    tmr <= tmr + TW'(1);
                end
                EJECT: if (i_eject_ack) begin
                    rem   <= rem - 3'd1;
                    tmr   <= '0;
                    state <= rem == 3'd1 ? DONE : GAP;
                end else if (tmr == TW'(EJECT_TIMEOUT - 1)) begin
                    tmr   <= '0;
                    state <= FAULT;
                end else begin
                    tmr <= tmr + TW'(1);
                end
                GAP:   state <= stock == '0 ? FAULT : EJECT;
                DONE:  state <= IDLE;
                FAULT: if (i_fault_clr) begin
                    rem   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // hopper stock: refill beats a simultaneous ack, never wraps below zero
    always_ff @(posedge i_clk) begin
        if (i_rst || i_refill) stock <= NICKEL_W'(NICKEL_INIT);
        else if (ack_ok && stock != '0) stock <= stock - NICKEL_W'(1);
    end
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl: scoreboard bench, sale events queued by stimulus and checked by a monitor
module tb_vend_dispense_ctrl;
    logic       i_clk = 0, i_rst = 1, i_vend = 0, i_eject_ack = 0, i_refill = 0, i_fault_clr = 0;
    logic [2:0] i_change = '0;
    logic       o_busy, o_motor, o_eject_req, o_done, o_change_fault, o_nickel_low;
    logic [5:0] o_nickel_cnt;

    typedef struct {int fault; int lat; int stock; int reqs;} exp_t;
    exp_t q[$];
    int   errors = 0, checks = 0, cyc = 0, v_cyc = 0, ack_limit = 100, acked = 0;
    int   reqs = 0, motor = 0;
    logic prev_req = 0, prev_fault = 0;

    vend_dispense_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_vend(i_vend), .i_change(i_change),
        .i_eject_ack(i_eject_ack), .i_refill(i_refill), .i_fault_clr(i_fault_clr),
        .o_busy(o_busy), .o_motor(o_motor), .o_eject_req(o_eject_req), .o_done(o_done),
        .o_change_fault(o_change_fault), .o_nickel_low(o_nickel_low), .o_nickel_cnt(o_nickel_cnt)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // hopper model: acks in the first req cycle until this sale's ack budget is used up
    initial forever begin
        @(posedge i_clk);
        if (i_vend) acked = 0;
        else if (i_eject_ack) acked++;
        #1;
        i_eject_ack = o_eject_req && acked < ack_limit;
    end

    // monitor: on o_done or a rising fault, pop the expected sale outcome and compare
    always @(negedge i_clk) begin
        exp_t e;
        if (i_rst) begin
            reqs = 0; motor = 0; prev_req = 0; prev_fault = 0;
        end else begin
            if (o_eject_req && !prev_req) reqs++;
            if (o_motor) motor++;
            if (o_done || (o_change_fault && !prev_fault)) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got done=%0d fault=%0d expected no event", o_done, o_change_fault);
                end else begin
                    e = q.pop_front();
                    check("kind_fault", int'(o_change_fault), e.fault);
                    check("kind_done", int'(o_done), 1 - e.fault);
                    check("latency", cyc - v_cyc, e.lat);
                    check("stock", int'(o_nickel_cnt), e.stock);
                    check("nickel_low", int'(o_nickel_low), int'(e.stock <= 4));
                    check("req_count", reqs, e.reqs);
                    check("motor_cycles", motor, 8);
                    check("busy_at_event", int'(o_busy), 1);
                end
                reqs = 0; motor = 0;
            end
            prev_req = o_eject_req; prev_fault = o_change_fault;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic do_reset();
        i_rst = 1; tick(2); i_rst = 0;
        check("rst_busy", int'(o_busy), 0);
        check("rst_motor", int'(o_motor), 0);
        check("rst_req", int'(o_eject_req), 0);
        check("rst_done", int'(o_done), 0);
        check("rst_fault", int'(o_change_fault), 0);
        check("rst_cnt", int'(o_nickel_cnt), 31);
        check("rst_low", int'(o_nickel_low), 0);
    endtask

    task automatic sale(input int ch, input int lim, input int f, input int lat, input int st, input int rq);
        exp_t e;
        e.fault = f; e.lat = lat; e.stock = st; e.reqs = rq;
        q.push_back(e);
        ack_limit = lim;
        i_change = 3'(ch); i_vend = 1; v_cyc = cyc + 1;
        tick();
        i_vend = 0; i_change = '0;
    endtask

    task automatic wait_events();
        int n = 0;
        while (q.size() > 0 && n < 80) begin tick(); n++; end
        if (q.size() > 0) begin
            checks++; errors++;
            $display("FAIL event_timeout: got %0d pending events expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic clear_fault();
        i_fault_clr = 1; tick(); i_fault_clr = 0;
        check("clr_busy", int'(o_busy), 0);
        check("clr_fault", int'(o_change_fault), 0);
    endtask

    initial begin
        bit seen;
        do_reset();
        tick(20);
        check("idle_busy", int'(o_busy), 0);
        check("idle_cnt", int'(o_nickel_cnt), 31);
        // no change: done after 8 motor cycles
        sale(0, 100, 0, 8, 31, 0);
        wait_events(); tick(2);
        check("s1_idle", int'(o_busy), 0);
        // change 3 with a stray vend during EJECT
        do_reset();
        sale(3, 100, 0, 13, 28, 3);
        tick(8);
        i_vend = 1; i_change = 3'd4; tick(); i_vend = 0; i_change = '0;
        wait_events(); tick(2);
        check("s2_idle", int'(o_busy), 0);
        check("s2_cnt", int'(o_nickel_cnt), 28);
        // code 7 saturates to 4
        do_reset();
        sale(7, 100, 0, 15, 27, 4);
        wait_events(); tick(2);
        // second nickel never acked
        do_reset();
        sale(2, 1, 1, 26, 30, 2);
        wait_events();
        i_vend = 1; i_change = 3'd1; tick(); i_vend = 0; i_change = '0;
        tick(3);
        check("fault_hold", int'(o_change_fault), 1);
        check("fault_busy", int'(o_busy), 1);
        check("fault_req", int'(o_eject_req), 0);
        clear_fault();
        check("fault_cnt", int'(o_nickel_cnt), 30);
        // drain stock down to 1
        do_reset();
        for (int i = 0; i < 7; i++) begin
            sale(4, 100, 0, 15, 27 - 4 * i, 4);
            wait_events(); tick(2);
        end
        sale(2, 100, 0, 11, 1, 2);
        wait_events(); tick(2);
        check("low_at_1", int'(o_nickel_low), 1);
        // exhaustion mid-change: fault after the gap
        sale(2, 100, 1, 10, 0, 1);
        wait_events();
        check("empty_cnt", int'(o_nickel_cnt), 0);
        clear_fault();
        // empty stock with change owed: fault straight out of MOTOR
        sale(1, 100, 1, 8, 0, 0);
        wait_events();
        clear_fault();
        i_refill = 1; tick(); i_refill = 0;
        check("refill_cnt", int'(o_nickel_cnt), 31);
        check("refill_low", int'(o_nickel_low), 0);
        // refill coinciding with an accepted ack wins
        sale(1, 100, 0, 9, 31, 1);
        seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (o_eject_req) begin
                seen = 1;
                i_refill = 1; tick(); i_refill = 0;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL refill_req_timeout: got no eject request expected one");
        end
        wait_events(); tick(2);
        check("final_idle", int'(o_busy), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
Dispense sequencer behind the coin-counting vending FSM. On each sale strobe it runs the soda motor for a fixed time, then pays out change one nickel at a time through a req/ack handshake with the nickel hopper. It also tracks hopper stock and reports faults. It is the only block that drives the motor and hopper.

Parameters:
MOTOR_CYCLES, 8, cycles o_motor is held high per sale (>=1)
EJECT_TIMEOUT, 16, max cycles o_eject_req may stay high without ack before FAULT (>=2)
NICKEL_W, 6, width of hopper stock counter
NICKEL_INIT, 31, stock value loaded at reset and on i_refill (<2^NICKEL_W)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_vend  input  1  sale strobe (1 cycle) from vending FSM
i_change  input  3  nickels to return with this sale (0-4), valid with i_vend
i_eject_ack  input  1  hopper acknowledges one nickel ejected
i_refill  input  1  hopper refilled, reload stock counter
i_fault_clr  input  1  clear fault, return to IDLE
o_busy  output  1  high in every state except IDLE
o_motor  output  1  soda motor drive
o_eject_req  output  1  request hopper to eject one nickel
o_done  output  1  1-cycle pulse at sale completion
o_change_fault  output  1  high while in FAULT
o_nickel_low  output  1  stock counter <= 4
o_nickel_cnt  output  NICKEL_W  current hopper stock

Behaviour:
- Reset (i_rst=1 at edge): state IDLE; o_busy, o_motor, o_eject_req, o_done, o_change_fault = 0; stock = NICKEL_INIT; remaining = 0; timers = 0. Reset overrides every other input in every state.
- Registered states: IDLE, MOTOR, EJECT, GAP, DONE, FAULT. All outputs decode from registered state or counters; there is no input-to-output combinational path.
- IDLE: i_vend=1 latches remaining = min(i_change, 4). Codes 5-7 saturate to 4. Go to MOTOR. i_vend in any other state is ignored. Upstream must respect o_busy.
- MOTOR: o_motor=1 for exactly MOTOR_CYCLES cycles after the accepting edge. Then go to DONE if remaining=0, to FAULT if stock=0, else to EJECT.
- EJECT: o_eject_req=1 and the timeout counter runs from 0.
  - i_eject_ack=1 sampled: remaining--, stock--. If the new remaining is 0, go to DONE; else go to GAP.
  - No ack by the EJECT_TIMEOUT-th cycle in EJECT: go to FAULT. An ack on that final cycle counts as an ack.
- GAP: 1 cycle with o_eject_req=0 (hopper re-arm). Then go to FAULT if stock=0, else to EJECT.
- DONE: o_done=1 for 1 cycle, then IDLE.
- FAULT: o_change_fault=1, o_eject_req=0, o_busy=1. Remaining nickels are not paid. Exit to IDLE on i_fault_clr=1 (remaining cleared). i_vend is ignored.
- Sale timing with change 0: o_busy high for MOTOR_CYCLES+1 cycles; o_done on the last of them.
- Sale timing with change N and immediate acks: each nickel takes 1 EJECT cycle plus 1 GAP cycle, except the last, which has no GAP.
- i_eject_ack outside EJECT is ignored.
- Stock counter:
  - Decrements only on an accepted ack and never goes below 0.
  - i_refill=1 loads NICKEL_INIT in any state. If it coincides with an accepted ack, refill wins and no decrement happens.
  - o_nickel_cnt mirrors the register; o_nickel_low = (stock <= 4).

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles -> all outputs 0, o_nickel_cnt=31, o_nickel_low=0. Then i_vend=0 for 20 cycles -> no change.
- Sale, no change: i_vend=1, i_change=0 -> o_motor high exactly 8 cycles, o_done pulses on cycle 9, o_busy high for cycles 1-9, stock stays 31.
- Sale, change 3, ack one cycle after each req -> 3 req/ack pairs separated by 1-cycle gaps, o_done after the 3rd ack, stock 28. An i_vend pulsed mid-sequence is ignored.
- Change code 7 -> exactly 4 nickels paid, stock 27.
- Timeout: change 2, first ack given, second never acked -> FAULT exactly 16 cycles after the 2nd req rises, o_change_fault=1, stock 30, no o_done. i_fault_clr -> IDLE next cycle, o_busy=0.
- Stock exhaustion and refill: load stock to 1, sale with change 2 -> 1 nickel paid, stock 0, o_nickel_low=1, FAULT after GAP. Then i_refill together with an ack in a later sale -> stock=31 (refill wins).
